sdram_arbit: RTL and testbench
==============================

SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have parameters: REFR_WAIT_MAX, 64, max cycles refr_req may wait in IDLE/WRITE/READ before refr_late sets; NOP_CMD, 4'b0111, idle command {cs_n,ras_n,cas_n,we_n}.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 sys_clk  in  1  system clock; all state changes on its rising edge.
REQ-004 sys_rst  in  1  synchronous active-high reset.
REQ-005 init_end  in  1  power-up init complete, level.
REQ-006 init_cmd / init_ba / init_addr  in  4/2/12  init sequencer command, bank, address.
REQ-007 refr_req / refr_end  in  1/1  refresh request (held until serviced); refresh done (held while refr_en high).
REQ-008 refr_cmd / refr_addr  in  4/12  refresh command and address (A10 high).
REQ-009 wr_req / wr_end  in  1/1  write burst request; write burst done (1-cycle pulse).
REQ-010 wr_cmd / wr_ba / wr_addr  in  4/2/12  write command, bank, address.
REQ-011 wr_sdram_en / wr_data  in  1/16  write data valid; write data.
REQ-012 rd_req / rd_end  in  1/1  read burst request; read burst done (1-cycle pulse).
REQ-013 rd_cmd / rd_ba / rd_addr  in  4/2/12  read command, bank, address.
REQ-014 refr_en / wr_en / rd_en  out  1/1/1  grant to refresher / writer / reader.
REQ-015 sdram_cmd / sdram_ba / sdram_addr  out  4/2/12  muxed SDRAM command bus.
REQ-016 sdram_dq_out / sdram_dq_oe  out  16/1  write data and tristate enable for DQ pad.
REQ-017 refr_late  out  1  sticky: refresh request waited > REFR_WAIT_MAX cycles.

Function
REQ-018 SHALL implement registered one-hot-decodable FSM states INIT, IDLE, AREF, WRITE, READ.
REQ-019 INIT -> IDLE when init_end=1; otherwise stay INIT.
REQ-020 IDLE: priority refr_req > wr_req > rd_req; next state AREF / WRITE / READ respectively; none -> stay IDLE.
REQ-021 AREF -> IDLE on refr_end=1; WRITE -> IDLE on wr_end=1; READ -> IDLE on rd_end=1; no preemption of an active grant.
REQ-022 IDLE after any grant SHALL last at least one cycle before the next grant (no back-to-back state transfer).
REQ-023 refr_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ); decoded from state register, zero added latency; at most one high.
REQ-024 Command mux (combinational from state): INIT -> init_*; AREF -> refr_cmd, ba=2'b00, refr_addr; WRITE -> wr_*; READ -> rd_*; IDLE -> NOP_CMD, ba=0, addr=0.
REQ-025 sdram_dq_oe = (state==WRITE) & wr_sdram_en; sdram_dq_out = wr_data when oe, else 16'd0.
REQ-026 refr_wait counter (7 bits, saturating) SHALL increment each cycle refr_req=1 and state!=AREF, clear when state==AREF or refr_req=0.
REQ-027 refr_late SHALL set the cycle after refr_wait reaches REFR_WAIT_MAX; cleared only by reset.
REQ-028 refr_end arriving while not in AREF, or wr_end/rd_end outside its state, SHALL be ignored.
REQ-029 refr_req and wr_req rising in the same IDLE cycle -> AREF; wr_req SHALL remain pending and be granted after refresh completes.
REQ-030 Requests in INIT SHALL be ignored until init_end.

Reset
REQ-031 On sys_rst=1 at a clock edge: state=INIT, refr_wait=0, refr_late=0; all grants 0, sdram_dq_oe=0, sdram_cmd follows init_cmd.
REQ-032 Reset asserted mid-grant SHALL drop the grant in the next cycle with no completion handshake required.

Structure
REQ-033 SDRAM command encodings (NOP, PRE, AREF, ACT, WR, RD, MRS) and state encodings SHALL live in a shared sdram_pkg package used by all SDRAM blocks.
REQ-034 The refresh-wait watchdog (REQ-026/027) SHALL be a sub-module sdram_refr_watchdog; FSM and mux stay in sdram_arbit.

Verification
REQ-035 Reset, init_end=0 for 100 cycles then 1 -> INIT held, state IDLE one cycle after init_end, sdram_cmd=4'b0111.
REQ-036 refr_req=1 in IDLE, refr_end asserted 5 cycles later -> refr_en=1 next cycle for 6 cycles, sdram_addr=12'h400 during AREF, refr_en=0 the cycle after refr_end seen.
REQ-037 refr_req and wr_req same cycle -> refr_en first; wr_en rises 2 cycles after refr_end (IDLE gap); no overlap.
REQ-038 wr_req granted, wr_sdram_en=1 with wr_data=16'hA5A5 -> sdram_dq_oe=1, sdram_dq_out=16'hA5A5; refr_req held during 70-cycle write -> refr_late=1, refresh granted after wr_end.
REQ-039 sys_rst pulsed during READ -> rd_en=0 next cycle, state INIT, refr_late=0.
REQ-040 Stray wr_end while in AREF -> ignored, refr_en stays 1 until refr_end.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n}
// and the arbiter state encoding used by all SDRAM blocks.
package sdram_pkg;

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_RD   = 4'b0101;
   localparam logic [3:0] CMD_MRS  = 4'b0000;

   localparam int REFR_WAIT_W = 7;

   // One-hot so each grant is a single register bit.
   typedef enum logic [4:0] {
      ST_INIT  = 5'b00001,
      ST_IDLE  = 5'b00010,
      ST_AREF  = 5'b00100,
      ST_WRITE = 5'b01000,
      ST_READ  = 5'b10000
   } arb_state_t;

endpackage

// File: rtl/sdram_refr_watchdog.sv
// Counts how long a refresh request has been waiting for its grant and
// raises a sticky flag once it has waited longer than REFR_WAIT_MAX cycles.
module sdram_refr_watchdog
   import sdram_pkg::*;
#(
   parameter int unsigned REFR_WAIT_MAX = 64
) (
   input  logic clk,
   input  logic srst,
   input  logic refr_req_i,
   input  logic in_aref_i,
   output logic refr_late_o
);

   localparam logic [REFR_WAIT_W-1:0] WAIT_MAX = REFR_WAIT_W'(REFR_WAIT_MAX);
   localparam logic [REFR_WAIT_W-1:0] WAIT_SAT = '1;

   logic [REFR_WAIT_W-1:0] wait_q, wait_d;
   logic                   late_q, late_d;

   always_comb begin
      wait_d = wait_q;
      late_d = late_q;
      if (in_aref_i || !refr_req_i) begin
         wait_d = '0;
      end else if (wait_q != WAIT_SAT) begin
         wait_d = wait_q + 1'b1;
      end
      if (wait_q >= WAIT_MAX) begin
         late_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wait_q <= '0;
         late_q <= 1'b0;
      end else begin
         wait_q <= wait_d;
         late_q <= late_d;
      end
   end

   assign refr_late_o = late_q;

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: grants init/refresh/write/read access one at a time
// and muxes the winning requester onto the SDRAM command and DQ buses.
module sdram_arbit
   import sdram_pkg::*;
#(
   parameter int unsigned REFR_WAIT_MAX = 64,
   parameter logic [3:0]  NOP_CMD       = 4'b0111
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        init_end,
   input  logic [3:0]  init_cmd,
   input  logic [1:0]  init_ba,
   input  logic [11:0] init_addr,
   input  logic        refr_req,
   input  logic        refr_end,
   input  logic [3:0]  refr_cmd,
   input  logic [11:0] refr_addr,
   input  logic        wr_req,
   input  logic        wr_end,
   input  logic [3:0]  wr_cmd,
   input  logic [1:0]  wr_ba,
   input  logic [11:0] wr_addr,
   input  logic        wr_sdram_en,
   input  logic [15:0] wr_data,
   input  logic        rd_req,
   input  logic        rd_end,
   input  logic [3:0]  rd_cmd,
   input  logic [1:0]  rd_ba,
   input  logic [11:0] rd_addr,
   output logic        refr_en,
   output logic        wr_en,
   output logic        rd_en,
   output logic [3:0]  sdram_cmd,
   output logic [1:0]  sdram_ba,
   output logic [11:0] sdram_addr,
   output logic [15:0] sdram_dq_out,
   output logic        sdram_dq_oe,
   output logic        refr_late
);

   arb_state_t state_q, state_d;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Every grant returns through IDLE, which guarantees a one-cycle gap
   // between consecutive grants.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_INIT:  if (init_end) state_d = ST_IDLE;
         ST_IDLE: begin
            if (refr_req)    state_d = ST_AREF;
            else if (wr_req) state_d = ST_WRITE;
            else if (rd_req) state_d = ST_READ;
         end
         ST_AREF:  if (refr_end) state_d = ST_IDLE;
         ST_WRITE: if (wr_end)   state_d = ST_IDLE;
         ST_READ:  if (rd_end)   state_d = ST_IDLE;
         default:  state_d = ST_INIT;
      endcase
   end

   assign refr_en = (state_q == ST_AREF);
   assign wr_en   = (state_q == ST_WRITE);
   assign rd_en   = (state_q == ST_READ);

   always_comb begin
      sdram_cmd  = NOP_CMD;
      sdram_ba   = 2'b00;
      sdram_addr = 12'd0;
      unique case (state_q)
         ST_INIT: begin
            sdram_cmd  = init_cmd;
            sdram_ba   = init_ba;
            sdram_addr = init_addr;
         end
         ST_AREF: begin
            sdram_cmd  = refr_cmd;
            sdram_addr = refr_addr;
         end
         ST_WRITE: begin
            sdram_cmd  = wr_cmd;
            sdram_ba   = wr_ba;
            sdram_addr = wr_addr;
         end
         ST_READ: begin
            sdram_cmd  = rd_cmd;
            sdram_ba   = rd_ba;
            sdram_addr = rd_addr;
         end
         default: ;
      endcase
   end

   assign sdram_dq_oe  = wr_en & wr_sdram_en;
   assign sdram_dq_out = sdram_dq_oe ? wr_data : 16'd0;

   sdram_refr_watchdog #(
      .REFR_WAIT_MAX(REFR_WAIT_MAX)
   ) u_refr_watchdog (
      .clk        (sys_clk),
      .srst       (sys_rst),
      .refr_req_i (refr_req),
      .in_aref_i  (refr_en),
      .refr_late_o(refr_late)
   );

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: init hand-off, refresh, write/refresh
// collision, late-refresh watchdog, stray handshakes and mid-read reset.
module tb_sdram_arbit;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        init_end;
   logic [3:0]  init_cmd;
   logic [1:0]  init_ba;
   logic [11:0] init_addr;
   logic        refr_req, refr_end;
   logic [3:0]  refr_cmd;
   logic [11:0] refr_addr;
   logic        wr_req, wr_end;
   logic [3:0]  wr_cmd;
   logic [1:0]  wr_ba;
   logic [11:0] wr_addr;
   logic        wr_sdram_en;
   logic [15:0] wr_data;
   logic        rd_req, rd_end;
   logic [3:0]  rd_cmd;
   logic [1:0]  rd_ba;
   logic [11:0] rd_addr;
   logic        refr_en, wr_en, rd_en;
   logic [3:0]  sdram_cmd;
   logic [1:0]  sdram_ba;
   logic [11:0] sdram_addr;
   logic [15:0] sdram_dq_out;
   logic        sdram_dq_oe;
   logic        refr_late;

   int n_vec = 0;
   int n_err = 0;

   always #5 sys_clk = ~sys_clk;

   sdram_arbit #(.REFR_WAIT_MAX(64), .NOP_CMD(4'b0111)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
      .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
      .refr_req(refr_req), .refr_end(refr_end), .refr_cmd(refr_cmd),
      .refr_addr(refr_addr), .wr_req(wr_req), .wr_end(wr_end),
      .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
      .wr_sdram_en(wr_sdram_en), .wr_data(wr_data), .rd_req(rd_req),
      .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
      .refr_en(refr_en), .wr_en(wr_en), .rd_en(rd_en),
      .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
      .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
      .refr_late(refr_late)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic chk_grants(input string tag, input logic r, input logic w, input logic d);
      chk({tag, ".refr_en"}, 32'(refr_en), 32'(r));
      chk({tag, ".wr_en"},   32'(wr_en),   32'(w));
      chk({tag, ".rd_en"},   32'(rd_en),   32'(d));
   endtask

   initial begin
      sys_rst = 1'b1; init_end = 1'b0;
      init_cmd = 4'b0010; init_ba = 2'b11; init_addr = 12'h5A5;
      refr_req = 1'b0; refr_end = 1'b0; refr_cmd = 4'b0001; refr_addr = 12'h400;
      wr_req = 1'b0; wr_end = 1'b0; wr_cmd = 4'b0100; wr_ba = 2'b10; wr_addr = 12'h123;
      wr_sdram_en = 1'b0; wr_data = 16'h0000;
      rd_req = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_ba = 2'b01; rd_addr = 12'h3C0;

      // Reset state: INIT drives init_* on the bus, no grants
      tick(2);
      chk_grants("rst", 1'b0, 1'b0, 1'b0);
      chk("rst.cmd", 32'(sdram_cmd), 32'h2);
      chk("rst.ba", 32'(sdram_ba), 32'h3);
      chk("rst.addr", 32'(sdram_addr), 32'h5A5);
      chk("rst.oe", 32'(sdram_dq_oe), 32'h0);
      chk("rst.late", 32'(refr_late), 32'h0);
      sys_rst = 1'b0;

      // Held in INIT for 100 cycles; a write request there is ignored
      wr_req = 1'b1;
      tick(100);
      chk("init.hold.cmd", 32'(sdram_cmd), 32'h2);
      chk_grants("init.hold", 1'b0, 1'b0, 1'b0);
      wr_req = 1'b0; init_end = 1'b1;
      tick(1);
      chk("idle.cmd", 32'(sdram_cmd), 32'h7);
      chk("idle.ba", 32'(sdram_ba), 32'h0);
      chk("idle.addr", 32'(sdram_addr), 32'h0);

      // Refresh: grant next cycle, 6 cycles, stray wr_end ignored
      refr_req = 1'b1;
      tick(1);
      refr_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("aref.en%0d", i), 32'(refr_en), 32'h1);
         chk($sformatf("aref.addr%0d", i), 32'(sdram_addr), 32'h400);
         chk($sformatf("aref.cmd%0d", i), 32'(sdram_cmd), 32'h1);
         wr_end = (i == 0);
         refr_end = (i == 5);
         tick(1);
      end
      refr_end = 1'b0;
      chk_grants("aref.done", 1'b0, 1'b0, 1'b0);
      chk("aref.done.cmd", 32'(sdram_cmd), 32'h7);

      // Refresh and write requested together: refresh wins, write follows after a gap
      refr_req = 1'b1; wr_req = 1'b1;
      tick(1);
      chk_grants("coll.aref", 1'b1, 1'b0, 1'b0);
      refr_req = 1'b0; refr_end = 1'b1;
      tick(1);
      refr_end = 1'b0;
      chk_grants("coll.gap", 1'b0, 1'b0, 1'b0);
      tick(1);
      chk_grants("coll.wr", 1'b0, 1'b1, 1'b0);
      wr_req = 1'b0;

      // Write muxing and DQ drive
      chk("wr.cmd", 32'(sdram_cmd), 32'h4);
      chk("wr.ba", 32'(sdram_ba), 32'h2);
      chk("wr.addr", 32'(sdram_addr), 32'h123);
      chk("wr.oe.off", 32'(sdram_dq_oe), 32'h0);
      chk("wr.dq.off", 32'(sdram_dq_out), 32'h0);
      wr_sdram_en = 1'b1; wr_data = 16'hA5A5;
      #1;
      chk("wr.oe.on", 32'(sdram_dq_oe), 32'h1);
      chk("wr.dq.on", 32'(sdram_dq_out), 32'hA5A5);

      // Refresh starved behind a long write: late after 65 edges of waiting
      refr_req = 1'b1; rd_end = 1'b1;
      tick(1);
      rd_end = 1'b0;
      chk_grants("late.stray_rd_end", 1'b0, 1'b1, 1'b0);
      tick(63);
      chk("late.edge64", 32'(refr_late), 32'h0);
      tick(1);
      chk("late.edge65", 32'(refr_late), 32'h1);
      tick(5);
      chk_grants("late.still_wr", 1'b0, 1'b1, 1'b0);
      wr_end = 1'b1;
      tick(1);
      wr_end = 1'b0;
      chk_grants("late.gap", 1'b0, 1'b0, 1'b0);
      chk("late.gap.oe", 32'(sdram_dq_oe), 32'h0);
      chk("late.gap.dq", 32'(sdram_dq_out), 32'h0);
      wr_sdram_en = 1'b0;
      tick(1);
      chk_grants("late.aref", 1'b1, 1'b0, 1'b0);
      refr_req = 1'b0; refr_end = 1'b1;
      tick(1);
      refr_end = 1'b0;
      chk("late.sticky", 32'(refr_late), 32'h1);

      // Read, then reset in the middle of it
      rd_req = 1'b1;
      tick(1);
      rd_req = 1'b0;
      chk_grants("rd", 1'b0, 1'b0, 1'b1);
      chk("rd.cmd", 32'(sdram_cmd), 32'h5);
      chk("rd.ba", 32'(sdram_ba), 32'h1);
      chk("rd.addr", 32'(sdram_addr), 32'h3C0);
      tick(1);
      chk_grants("rd.hold", 1'b0, 1'b0, 1'b1);
      sys_rst = 1'b1;
      tick(1);
      sys_rst = 1'b0;
      chk_grants("rd.rst", 1'b0, 1'b0, 1'b0);
      chk("rd.rst.cmd", 32'(sdram_cmd), 32'h2);
      chk("rd.rst.late", 32'(refr_late), 32'h0);

      // Back to IDLE, then write beats read
      tick(1);
      chk("post.idle.cmd", 32'(sdram_cmd), 32'h7);
      wr_req = 1'b1; rd_req = 1'b1;
      tick(1);
      chk_grants("prio", 1'b0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
